// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the instruction fetch PC sequencer.
package pc_sequencer_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DROP
  } state_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Single-outstanding instruction fetch sequencer with branch redirect,
// in-flight response dropping and registered flush/misalign pulses.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_valid,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic            flush,
  output logic            misalign
);

  state_t          r_state;
  state_t          w_next;
  logic            w_redirect;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_instr_valid;
  logic            r_imem_req;
  logic            r_flush;
  logic            r_misalign;

  assign w_redirect = branch_valid && branch_taken && (r_state != S_BOOT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT: w_next = S_REQ;
      S_REQ:  w_next = imem_gnt ? (w_redirect ? S_DROP : S_WAIT) : S_REQ;
      S_WAIT: begin
        if (imem_rvalid)     w_next = w_redirect ? S_REQ : S_OUT;
        else if (w_redirect) w_next = S_DROP;
      end
      S_OUT: begin
        if (w_redirect || !stall) w_next = S_REQ;
      end
      S_DROP: begin
        if (imem_rvalid && !w_redirect) w_next = S_REQ;
      end
      default: w_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
      r_flush       <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_imem_req <= (w_next == S_REQ);
      r_flush    <= w_redirect;
      r_misalign <= w_redirect && (branch_target[1:0] != 2'b00);
      // Redirect outranks both the WAIT capture and the OUT acceptance.
      if (w_redirect) begin
        r_pc          <= align_pc(branch_target);
        r_instr_valid <= 1'b0;
      end else begin
        case (r_state)
          S_WAIT: begin
            if (imem_rvalid) begin
              r_instr       <= imem_rdata;
              r_instr_valid <= 1'b1;
            end
          end
          S_OUT: begin
            if (!stall) begin
              r_pc          <= r_pc + PC_STEP;
              r_instr_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign flush       = r_flush;
  assign misalign    = r_misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer with an abstract fetch-stream model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_valid;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        flush;
  logic        misalign;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .flush        (flush),
    .misalign     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        flush;
    logic        mis;
    logic        iv;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_vec;
  int unsigned n_err;
  int unsigned n_acc;
  int unsigned idle;

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Abstract model / memory responder state.
  logic        pend;
  logic [31:0] paddr;
  int unsigned pdelay;
  logic        m_drop;
  logic [31:0] m_pc;

  // Monitor: one expectation per clock edge once issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (flush !== e.flush) begin
          n_err++; $display("FAIL flush: got %b want %b @%0t", flush, e.flush, $time);
        end
        if (misalign !== e.mis) begin
          n_err++; $display("FAIL misalign: got %b want %b @%0t", misalign, e.mis, $time);
        end
        if (instr_valid !== e.iv) begin
          n_err++; $display("FAIL instr_valid: got %b want %b @%0t", instr_valid, e.iv, $time);
        end
        if (pc !== e.pc) begin
          n_err++; $display("FAIL pc: got %h want %h @%0t", pc, e.pc, $time);
        end
        if (imem_addr !== e.pc) begin
          n_err++; $display("FAIL imem_addr: got %h want %h @%0t", imem_addr, e.pc, $time);
        end
        if (e.iv && instr !== memf(e.pc)) begin
          n_err++; $display("FAIL instr: got %h want %h @%0t", instr, memf(e.pc), $time);
        end
        if (e.iv && imem_req !== 1'b0) begin
          n_err++; $display("FAIL req_in_out: got %b want 0 @%0t", imem_req, $time);
        end
      end
    end
  end

  task automatic step(input int unsigned p_stall, input int unsigned p_br,
                      input int unsigned p_gnt, input int unsigned max_dly);
    logic        cur_req, cur_iv, rv, g, st, bv, bt, redir, pend_old;
    logic [31:0] tgt;
    exp_t        x;
    @(negedge clk);
    cur_req = imem_req;
    cur_iv  = instr_valid;
    rv      = pend && (pdelay == 0);
    st      = ($urandom % 100) < p_stall;
    case ($urandom % 4)
      0:       tgt = 32'h0000_0100;
      1:       tgt = 32'h0000_0102;
      2:       tgt = 32'hFFFF_FFFC;
      default: tgt = $urandom;
    endcase
    bv = ($urandom % 100) < p_br;
    bt = 1'($urandom % 2);
    // A redirect while a stale response lands would leave no response to drain.
    if (rv && m_drop) bv = 1'b0;
    redir = bv && bt;
    g     = cur_req && (($urandom % 100) < p_gnt);

    stall         = st;
    branch_valid  = bv;
    branch_taken  = bt;
    branch_target = tgt;
    imem_gnt      = g;
    imem_rvalid   = rv;
    imem_rdata    = rv ? memf(paddr) : $urandom;

    x.flush = redir;
    x.mis   = redir && (tgt[1:0] != 2'b00);
    x.iv    = redir ? 1'b0 : (cur_iv && st) ? 1'b1 : (rv && !m_drop);
    x.pc    = redir ? {tgt[31:2], 2'b00} : (cur_iv && !st) ? m_pc + 32'd4 : m_pc;
    if (cur_iv && !st && !redir) begin
      n_acc++;
      idle = 0;
    end else begin
      idle++;
    end
    if (idle > 60) begin
      n_err++; $display("FAIL watchdog: %0d idle cycles, want <= 60 @%0t", idle, $time);
      idle = 0;
    end

    pend_old = pend;
    if (rv) pend = 1'b0;
    else if (pend) pdelay--;
    if (g) begin
      pend   = 1'b1;
      paddr  = imem_addr;
      pdelay = $urandom % (max_dly + 1);
    end
    if (redir) m_drop = (pend_old && !rv) || g;
    else if (rv) m_drop = 1'b0;
    m_pc = x.pc;
    exp_q.push_back(x);
  endtask

  task automatic do_reset(input bit check);
    exp_t x;
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0; branch_valid = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    #1;
    if (check) begin
      n_vec++;
      if (pc !== RST_PC || imem_addr !== RST_PC) begin
        n_err++; $display("FAIL rst_pc: got %h want %h", pc, RST_PC);
      end
      if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
        n_err++; $display("FAIL rst_fetch: got instr=%h iv=%b req=%b want 0/0/0", instr, instr_valid, imem_req);
      end
      if (flush !== 1'b0 || misalign !== 1'b0) begin
        n_err++; $display("FAIL rst_pulse: got flush=%b mis=%b want 0/0", flush, misalign);
      end
    end
    exp_q.delete();
    pend = 1'b0; pdelay = 0; m_drop = 1'b0; m_pc = RST_PC; idle = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    x = '{flush: 1'b0, mis: 1'b0, iv: 1'b0, pc: RST_PC};
    exp_q.push_back(x);
  endtask

  task automatic phase(input int unsigned cycles, input int unsigned p_stall,
                       input int unsigned p_br, input int unsigned p_gnt,
                       input int unsigned max_dly);
    int unsigned a0;
    a0 = n_acc;
    repeat (cycles) step(p_stall, p_br, p_gnt, max_dly);
    n_vec++;
    if (n_acc - a0 < 5) begin
      n_err++; $display("FAIL progress: got %0d accepts want >= 5", n_acc - a0);
    end
  endtask

  initial begin
    int unsigned tries;
    n_vec = 0; n_err = 0; n_acc = 0; idle = 0;
    pend = 1'b0; paddr = '0; pdelay = 0; m_drop = 1'b0; m_pc = RST_PC;
    rst_n = 1'b0;
    stall = 1'b0; branch_valid = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    do_reset(1'b1);
    phase(200, 0, 0, 100, 0);
    phase(1500, 30, 10, 70, 2);
    tries = 0;
    while (!(pend && !m_drop) && tries < 200) begin
      step(20, 0, 80, 3);
      tries++;
    end
    n_vec++;
    if (!(pend && !m_drop)) begin
      n_err++; $display("FAIL wait_reach: got no outstanding fetch want one within 200 cycles");
    end
    do_reset(1'b1);
    phase(1500, 50, 25, 50, 3);
    phase(500, 0, 40, 100, 1);
    phase(300, 10, 5, 90, 0);
    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  decode not ready; instr is accepted when instr_valid=1 and stall=0.
REQ-005 branch_valid  input  1  resolved branch/jump present this cycle.
REQ-006 branch_taken  input  1  branch comparator result; qualified by branch_valid.
REQ-007 branch_target  input  32  redirect address.
REQ-008 imem_gnt  input  1  memory accepts the request this cycle.
REQ-009 imem_rvalid  input  1  read data valid this cycle.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 imem_req  output  1  fetch request.
REQ-012 imem_addr  output  32  fetch address, equal to pc.
REQ-013 pc  output  32  address of the current or pending fetch.
REQ-014 instr  output  32  fetched instruction, held while instr_valid=1.
REQ-015 instr_valid  output  1  instr is valid for decode.
REQ-016 flush  output  1  one-cycle registered pulse; younger pipeline stages shall be discarded.
REQ-017 misalign  output  1  one-cycle registered pulse; redirect target had bits [1:0] != 0.

Function
REQ-018 FSM states: BOOT, REQ, WAIT, OUT, DROP; one request in flight at most.
REQ-019 BOOT lasts exactly one cycle after reset release, then moves to REQ.
REQ-020 REQ: imem_req=1, imem_addr=pc; imem_gnt=1 -> WAIT.
REQ-021 WAIT: imem_rvalid=1 -> capture imem_rdata into instr, set instr_valid=1 next cycle, -> OUT.
REQ-022 OUT: instr_valid=1 and instr stable; stall=0 -> pc <= pc+4 (mod 2^32), instr_valid <= 0, -> REQ.
REQ-023 Redirect means branch_valid=1 and branch_taken=1; branch_valid=1 with branch_taken=0 has no effect.
REQ-024 On a redirect in REQ, WAIT, OUT or DROP, pc <= {branch_target[31:2],2'b00}, flush=1 next cycle, and instr_valid <= 0.
REQ-025 Redirect next-state: REQ without gnt -> REQ; REQ with gnt -> DROP; WAIT without rvalid -> DROP; WAIT with rvalid -> REQ (data discarded); OUT -> REQ; DROP -> DROP.
REQ-026 Redirect has priority over stall and over a same-cycle OUT acceptance.
REQ-027 misalign=1 the cycle after a redirect with branch_target[1:0] != 0; otherwise 0.
REQ-028 Redirects during BOOT are ignored.
REQ-029 DROP: imem_req=0, instr_valid=0; imem_rvalid=1 -> REQ with the response discarded.
REQ-030 imem_addr may change while imem_req=1 and imem_gnt=0, only as the result of a redirect.
REQ-031 imem_rvalid outside WAIT/DROP is ignored.

Reset
REQ-032 Asserting rst_n=0 in any state, including mid-transaction, forces: state=BOOT, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, flush=0, misalign=0.
REQ-033 A response arriving after reset release for a request issued before reset shall not be expected; memory is reset with the same rst_n.

Structure
REQ-034 The shared package holds the state enumeration and the instruction-width/increment constants (XLEN=32, PC_STEP=4).
REQ-035 The block is self-contained; branch comparison stays external, and no sub-module is required.

Verification
REQ-036 Reset release, gnt=1 and rvalid one cycle later -> first imem_addr=RESET_PC, instr_valid rises in the cycle after rvalid, next addr=RESET_PC+4.
REQ-037 stall=1 for 3 cycles in OUT -> instr and pc held, no imem_req; stall=0 -> REQ at pc+4.
REQ-038 Redirect to 0x0000_0100 in WAIT, rvalid 2 cycles later -> flush one cycle, DROP discards data, next imem_addr=0x100, instr_valid never high for the dropped word.
REQ-039 Redirect to 0x0000_0102 in OUT with stall=0 in the same cycle -> pc=0x100, misalign=1 and flush=1 for one cycle, no pc+4 advance.
REQ-040 pc=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000; branch_valid=1 with branch_taken=0 -> no flush, sequential flow.
REQ-041 rst_n low while in WAIT -> all outputs at reset values immediately, BOOT then fetch from RESET_PC.
